// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one word-addressed Memory between instruction fetch
// (port 0) and load/store (port 1), one transaction at a time.
//
// Request/ack handshake, for each port:
//   A requester raises rd_en_i and/or wr_en_i with addr_i/data_i and holds
//   them stable until it sees its one-cycle ack_o. It drops the enables in the
//   cycle after ack_o. If rd_en_i and wr_en_i are both set, the operation is a
//   read. data_o and err_o are valid only while ack_o=1 and are 0 otherwise.
//   On the Memory side, a one-cycle mem_rd_en_o/mem_wr_en_o strobe starts a
//   transaction. mem_ack_i is honoured only while the FSM is in S_WAIT.
//   If no ack arrives within TIMEOUT_CYCLES, the requester gets ack_o with
//   err_o=1 and data_o=0.
//
// The FSM state register state_q is a named enum so checkers can bind to it.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES   = 16,
  parameter bit          RESET_LAST_GRANT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_rd_en_i,
  input  logic        m0_wr_en_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_rd_en_i,
  input  logic        m1_wr_en_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  // TIMEOUT_CYCLES-1 is the largest counter value ever compared against.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_grant_q;
  logic              port_q;
  logic              op_rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              req0;
  logic              req1;
  logic              winner;
  logic              win_rd;
  logic [31:0]       win_addr;
  logic [31:0]       win_data;
  logic              timeout_hit;
  logic [31:0]       resp_data;
  logic              resp_err;

  assign req0 = m0_rd_en_i | m0_wr_en_i;
  assign req1 = m1_rd_en_i | m1_wr_en_i;

  // On a tie the port that did not win last time goes first.
  assign winner   = (req0 && req1) ? ~last_grant_q : req1;
  assign win_rd   = winner ? m1_rd_en_i : m0_rd_en_i;
  assign win_addr = winner ? m1_addr_i  : m0_addr_i;
  assign win_data = winner ? m1_data_i  : m0_data_i;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // A real ack wins over a timeout in the same cycle; writes return zero data.
  assign resp_err  = ~mem_ack_i;
  assign resp_data = (mem_ack_i && op_rd_q) ? mem_data_i : 32'd0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req0 || req1) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mem_ack_i || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latch, registered Memory strobes, timeout counter and port responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= RESET_LAST_GRANT;
      port_q       <= 1'b0;
      op_rd_q      <= 1'b0;
      cnt_q        <= '0;
      mem_rd_en_o  <= 1'b0;
      mem_wr_en_o  <= 1'b0;
      mem_addr_o   <= 32'd0;
      mem_data_o   <= 32'd0;
      m0_ack_o     <= 1'b0;
      m0_err_o     <= 1'b0;
      m0_data_o    <= 32'd0;
      m1_ack_o     <= 1'b0;
      m1_err_o     <= 1'b0;
      m1_data_o    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            port_q       <= winner;
            op_rd_q      <= win_rd;
            last_grant_q <= winner;
            mem_rd_en_o  <= win_rd;
            mem_wr_en_o  <= ~win_rd;
            mem_addr_o   <= win_addr;
            mem_data_o   <= win_data;
          end
        end
        S_ISSUE: begin
          mem_rd_en_o <= 1'b0;
          mem_wr_en_o <= 1'b0;
          cnt_q       <= '0;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ack_i || timeout_hit) begin
            if (port_q) begin
              m1_ack_o  <= 1'b1;
              m1_err_o  <= resp_err;
              m1_data_o <= resp_data;
            end else begin
              m0_ack_o  <= 1'b1;
              m0_err_o  <= resp_err;
              m0_data_o <= resp_data;
            end
          end
        end
        S_RESP: begin
          m0_ack_o  <= 1'b0;
          m0_err_o  <= 1'b0;
          m0_data_o <= 32'd0;
          m1_ack_o  <= 1'b0;
          m1_err_o  <= 1'b0;
          m1_data_o <= 32'd0;
        end
        default: begin
          mem_rd_en_o <= 1'b0;
          mem_wr_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized and directed stimulus for memory_arbiter,
// checked against a transaction-level model of the round-robin arbiter and a
// reference copy of the Memory contents.
module tb_memory_arbiter;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_rd_en_i, m0_wr_en_i, m1_rd_en_i, m1_wr_en_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        mem_rd_en_o, mem_wr_en_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;

  memory_arbiter #(.TIMEOUT_CYCLES(TMO), .RESET_LAST_GRANT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_en_i(m0_rd_en_i), .m0_wr_en_i(m0_wr_en_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_rd_en_i(m1_rd_en_i), .m1_wr_en_i(m1_wr_en_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  // ---------------- Memory stub (acks the cycle after its strobe) ----------------
  logic [31:0] smem [64];
  bit          stub = 1'b0;   // when set, the Memory never acks

  always @(posedge clk) begin
    mem_ack_i  <= 1'b0;
    mem_data_i <= $urandom;
    if (!stub && (mem_rd_en_o || mem_wr_en_o)) begin
      mem_ack_i <= 1'b1;
      if (mem_rd_en_o) mem_data_i <= smem[mem_addr_o[7:2]];
      else             smem[mem_addr_o[7:2]] = mem_data_o;
    end
  end

  // ---------------- reference model and scoreboard state ----------------
  logic [31:0] mdl [64];            // expected Memory contents
  bit          model_last = 1'b1;   // port granted most recently
  logic [65:0] exp_q [$];           // expected strobes {rd, wr, addr, data}
  logic [65:0] e;
  int          ack_cnt [2];
  int          exp_ack_cnt [2];
  int          viol = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  int          got_lat [2];
  logic [31:0] got_data [2];
  logic        got_err [2];
  logic        got_ok [2];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: strobe contents/order, stray ack data, per-port ack totals.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ack_o) ack_cnt[0]++;
      if (m1_ack_o) ack_cnt[1]++;
      if ((!m0_ack_o && (m0_data_o != 32'd0 || m0_err_o)) ||
          (!m1_ack_o && (m1_data_o != 32'd0 || m1_err_o)) ||
          (mem_rd_en_o && mem_wr_en_o)) viol++;
      if (mem_rd_en_o || mem_wr_en_o) begin
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", 72'({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o}), 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe", 72'({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o}), 72'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_port(input int p, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data);
    if (p == 0) begin
      m0_rd_en_i = rd; m0_wr_en_i = wr; m0_addr_i = addr; m0_data_i = data;
    end else begin
      m1_rd_en_i = rd; m1_wr_en_i = wr; m1_addr_i = addr; m1_data_i = data;
    end
  endtask

  // Wait (bounded) for port p's ack, record it, then release the port.
  task automatic wait_ack(input int p);
    int i;
    i = 0;
    got_ok[p] = 1'b0;
    while (!got_ok[p] && i < 60) begin
      @(negedge clk);
      i++;
      if ((p == 0) ? m0_ack_o : m1_ack_o) begin
        got_ok[p]   = 1'b1;
        got_lat[p]  = i;
        got_data[p] = (p == 0) ? m0_data_o : m1_data_o;
        got_err[p]  = (p == 0) ? m0_err_o : m1_err_o;
      end
    end
    drive_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // One round: the selected ports raise requests together and each holds
  // until acked. op: 0 read, 1 write, 2 read+write (behaves as read).
  task automatic run_round(input logic [1:0] sel,
                           input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] d1,
                           input bit tmo);
    logic [1:0]  rop [2];
    logic [31:0] ra [2];
    logic [31:0] rdat [2];
    int          order [2];
    int          ns;
    int          p;
    int          base;
    bit          is_rd;
    int          exp_lat [2];
    logic [31:0] exp_data [2];
    logic        exp_err [2];
    rop[0] = op0; ra[0] = a0; rdat[0] = d0;
    rop[1] = op1; ra[1] = a1; rdat[1] = d1;
    if (sel == 2'b11) begin
      order[0] = model_last ? 0 : 1;
      order[1] = 1 - order[0];
      ns = 2;
    end else begin
      order[0] = sel[1] ? 1 : 0;
      order[1] = 0;
      ns = 1;
    end
    base = tmo ? (TMO + 2) : 3;
    for (int k = 0; k < ns; k++) begin
      p = order[k];
      is_rd = (rop[p] != 2'd1);
      exp_q.push_back({is_rd, !is_rd, ra[p], rdat[p]});
      if (tmo) begin
        exp_data[p] = 32'd0;
        exp_err[p]  = 1'b1;
      end else if (is_rd) begin
        exp_data[p] = mdl[ra[p][7:2]];
        exp_err[p]  = 1'b0;
      end else begin
        mdl[ra[p][7:2]] = rdat[p];
        exp_data[p] = 32'd0;
        exp_err[p]  = 1'b0;
      end
      exp_lat[p] = base + k * (base + 1);
      exp_ack_cnt[p]++;
      model_last = (p == 1);
    end
    @(negedge clk);
    for (int q = 0; q < 2; q++)
      if (sel[q]) drive_port(q, rop[q] != 2'd1, rop[q] != 2'd0, ra[q], rdat[q]);
    fork
      begin if (sel[0]) wait_ack(0); end
      begin if (sel[1]) wait_ack(1); end
    join
    for (int q = 0; q < 2; q++) begin
      if (sel[q]) begin
        check($sformatf("p%0d_ack_seen", q), 72'(got_ok[q]), 72'd1);
        check($sformatf("p%0d_latency", q), 72'(got_lat[q]), 72'(exp_lat[q]));
        check($sformatf("p%0d_data", q), 72'(got_data[q]), 72'(exp_data[q]));
        check($sformatf("p%0d_err", q), 72'(got_err[q]), 72'(exp_err[q]));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  sel, o0, o1;
    logic [31:0] ad0, ad1;
    int          cnt, exp_port, port, base_ack;
    logic [31:0] alt_addr [2];

    for (int i = 0; i < 64; i++) begin
      smem[i] = $urandom;
      mdl[i]  = smem[i];
    end
    smem[1] = 32'hDEAD_BEEF;
    mdl[1]  = 32'hDEAD_BEEF;
    drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem", 72'({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o}), 72'd0);
    check("rst_ports", 72'({m0_ack_o, m0_err_o, m0_data_o, m1_ack_o, m1_err_o, m1_data_o}), 72'd0);
    rst = 1'b0;

    // Single read on port 0.
    run_round(2'b01, 2'd0, 32'h4, 32'h0, 2'd0, 32'h0, 32'h0, 1'b0);
    // Write then read on port 1.
    run_round(2'b10, 2'd0, 32'h0, 32'h0, 2'd1, 32'h10, 32'h1234_5678, 1'b0);
    run_round(2'b10, 2'd0, 32'h0, 32'h0, 2'd0, 32'h10, 32'h0, 1'b0);
    // Contention right after reset: port 0 first.
    do_reset();
    run_round(2'b11, 2'd0, 32'h0, 32'h0, 2'd0, 32'h8, 32'h0, 1'b0);

    // Both ports hold reads continuously: grants must alternate.
    alt_addr[0] = 32'h20;
    alt_addr[1] = 32'h28;
    exp_port = model_last ? 0 : 1;
    for (int k = 0; k < 6; k++) begin
      port = exp_port ^ (k & 1);
      exp_q.push_back({1'b1, 1'b0, alt_addr[port], 32'h0});
      exp_ack_cnt[port]++;
    end
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, alt_addr[0], 32'h0);
    drive_port(1, 1'b1, 1'b0, alt_addr[1], 32'h0);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 6; i++) begin
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) begin
        port = exp_port ^ (cnt & 1);
        check("alt_port", 72'({m1_ack_o, m0_ack_o}), 72'(port == 1 ? 2'b10 : 2'b01));
        check("alt_data", 72'(m1_ack_o ? m1_data_o : m0_data_o), 72'(mdl[alt_addr[port][7:2]]));
        model_last = (port == 1);
        cnt++;
        if (cnt == 6) begin
          drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
          drive_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
    end
    check("alt_count", 72'(cnt), 72'd6);

    // Read+write together behaves as a read; memory must not change.
    run_round(2'b01, 2'd2, 32'h18, 32'hA5A5_5A5A, 2'd0, 32'h0, 32'h0, 1'b0);
    run_round(2'b01, 2'd0, 32'h18, 32'h0, 2'd0, 32'h0, 32'h0, 1'b0);

    // Missing Memory ack: timeout with err, then a normal transaction.
    stub = 1'b1;
    run_round(2'b01, 2'd0, 32'h24, 32'h0, 2'd0, 32'h0, 32'h0, 1'b1);
    stub = 1'b0;
    run_round(2'b01, 2'd0, 32'h24, 32'h0, 2'd0, 32'h0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    stub = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 32'h20, 32'h55});
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 32'h20, 32'h55);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mem", 72'({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o}), 72'd0);
    check("async_rst_ports", 72'({m0_ack_o, m0_err_o, m0_data_o, m1_ack_o, m1_err_o, m1_data_o}), 72'd0);
    @(negedge clk);
    drive_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    stub = 1'b0;
    rst = 1'b0;
    model_last = 1'b1;
    base_ack = ack_cnt[0];
    repeat (25) @(negedge clk);
    check("no_ack_after_abort", 72'(ack_cnt[0]), 72'(base_ack));
    run_round(2'b11, 2'd0, 32'h30, 32'h0, 2'd0, 32'h34, 32'h0, 1'b0);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      sel = 2'($urandom_range(1, 3));
      o0  = 2'($urandom_range(0, 2));
      o1  = 2'($urandom_range(0, 2));
      ad0 = 32'($urandom_range(0, 15)) << 2;
      ad1 = 32'($urandom_range(0, 15)) << 2;
      run_round(sel, o0, ad0, $urandom, o1, ad1, $urandom, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drain", 72'(exp_q.size()), 72'd0);
    check("ack_cnt_p0", 72'(ack_cnt[0]), 72'(exp_ack_cnt[0]));
    check("ack_cnt_p1", 72'(ack_cnt[1]), 72'(exp_ack_cnt[1]));
    check("idle_outputs_zero", 72'(viol), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
